data_unscrambler: RTL and testbench

//  Inverse of the scramble datapath (register -> half-swap rotate -> multiply by key -> store).

---
 rtl/data_unscrambler.sv | 173 +++++++++++++++++
 tb/tb_data_unscrambler.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/data_unscrambler.sv
`default_nettype none
// ============================================================================
//  Module   : data_unscrambler
//  Purpose  : Recovers the original nibble from a stored scrambled product.
//             The product is divided by the key with a sequential restoring
//             divider (one quotient bit per cycle). The low WIDTH bits of
//             the quotient are then half-swapped back, which undoes the
//             rotation applied on the scramble side.
//  Ports    : clk        - clock, all state changes on rising edge
//             rst        - asynchronous active-high reset
//             i_start    - request, sampled only while idle
//             i_prod_in  - stored product (dividend), 2*WIDTH bits
//             i_key_in   - key (divisor), WIDTH bits
//             o_busy     - division in progress
//             o_done     - one-cycle pulse, results valid
//             o_num_out  - recovered nibble (half-swapped quotient low bits)
//             o_rem_out  - remainder, nonzero for a non-clean multiple
//             o_div_err  - key was zero when the request was accepted
//             o_ovf      - quotient did not fit in WIDTH bits
//  Revision : 1.0 - initial release
// ============================================================================
module data_unscrambler #(
    parameter int WIDTH = 4   // must be even so the half-swap is well defined
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [2*WIDTH-1:0]   i_prod_in,
    input  logic [WIDTH-1:0]     i_key_in,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [WIDTH-1:0]     o_num_out,
    output logic [WIDTH-1:0]     o_rem_out,
    output logic                 o_div_err,
    output logic                 o_ovf
);

    localparam int              c_QW    = 2 * WIDTH;
    localparam int              c_CW    = $clog2(c_QW + 1);
    localparam logic [c_CW-1:0] c_COUNT = c_CW'(c_QW);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [c_QW-1:0]    r_q;        // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0]   r_d;        // divisor frozen at acceptance
    // Between steps the partial remainder is always below the divisor, so
    // WIDTH bits hold it; only the shifted trial value needs the extra bit.
    logic [WIDTH-1:0]   r_r;
    logic [c_CW-1:0]    r_count;

    logic               r_done;
    logic [WIDTH-1:0]   r_num;
    logic [WIDTH-1:0]   r_rem;
    logic               r_div_err;
    logic               r_ovf;

    logic [WIDTH:0]     w_r_shift;
    logic [WIDTH:0]     w_r_sub;
    logic               w_ge;
    logic [WIDTH-1:0]   w_swap;
    logic               w_accept;

    // ------------------------------------------------------------------
    // One restoring division step
    // ------------------------------------------------------------------
    assign w_r_shift = {r_r, r_q[c_QW-1]};
    assign w_ge      = (w_r_shift >= {1'b0, r_d});
    assign w_r_sub   = w_r_shift - {1'b0, r_d};

    // Swapping the two halves of the low quotient nibble (self-inverse)
    assign w_swap    = {r_q[WIDTH/2-1:0], r_q[WIDTH-1:WIDTH/2]};

    assign w_accept  = (r_state == S_IDLE) && i_start;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    // A zero key skips the division entirely
                    w_next_state = (i_key_in == '0) ? S_DONE : S_DIV;
                end
            end
            S_DIV: begin
                // The step taken with count==1 is the last one
                if (r_count == c_CW'(1)) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q       <= '0;
            r_d       <= '0;
            r_r       <= '0;
            r_count   <= '0;
            r_done    <= 1'b0;
            r_num     <= '0;
            r_rem     <= '0;
            r_div_err <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_q       <= i_prod_in;
                        r_d       <= i_key_in;
                        r_r       <= '0;
                        r_count   <= c_COUNT;
                        r_div_err <= (i_key_in == '0);
                        r_ovf     <= 1'b0;
                    end
                end
                S_DIV: begin
                    r_r     <= WIDTH'(w_ge ? w_r_sub : w_r_shift);
                    r_q     <= {r_q[c_QW-2:0], w_ge};
                    r_count <= r_count - c_CW'(1);
                end
                S_DONE: begin
                    r_done <= 1'b1;
                    if (r_div_err) begin
                        r_num <= '0;
                        r_rem <= '0;
                        r_ovf <= 1'b0;
                    end else begin
                        r_num <= w_swap;
                        r_rem <= r_r;
                        r_ovf <= (r_q[c_QW-1:WIDTH] != '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy    = (r_state == S_DIV);
    assign o_done    = r_done;
    assign o_num_out = r_num;
    assign o_rem_out = r_rem;
    assign o_div_err = r_div_err;
    assign o_ovf     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_data_unscrambler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_unscrambler
//  Purpose  : Directed self-checking bench for data_unscrambler (WIDTH=4)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_unscrambler;

    localparam int WIDTH = 4;

    logic               clk;
    logic               rst;
    logic               i_start;
    logic [7:0]         i_prod_in;
    logic [3:0]         i_key_in;
    logic               o_busy;
    logic               o_done;
    logic [3:0]         o_num_out;
    logic [3:0]         o_rem_out;
    logic               o_div_err;
    logic               o_ovf;

    int n_checks   = 0;
    int n_failures = 0;
    int n_done     = 0;   // done pulses observed
    int n_accepted = 0;   // requests expected to complete

    data_unscrambler #(.WIDTH(WIDTH)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .i_start   (i_start),
        .i_prod_in (i_prod_in),
        .i_key_in  (i_key_in),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_num_out (o_num_out),
        .o_rem_out (o_rem_out),
        .o_div_err (o_div_err),
        .o_ovf     (o_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_done === 1'b1) n_done++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] num, input logic [3:0] rem,
                                 input logic ovf, input logic err);
        check({tag, ".num"}, 32'(o_num_out), 32'(num));
        check({tag, ".rem"}, 32'(o_rem_out), 32'(rem));
        check({tag, ".ovf"}, 32'(o_ovf),     32'(ovf));
        check({tag, ".err"}, 32'(o_div_err), 32'(err));
    endtask

    // Issue one request and wait (bounded) for done. With noise set, extra
    // start pulses are driven while busy and while in the DONE state.
    task automatic run_op(input string tag, input logic [7:0] prod, input logic [3:0] key,
                          input int exp_lat, input logic [3:0] num, input logic [3:0] rem,
                          input logic ovf, input logic err, input bit noise);
        int lat;
        @(negedge clk);
        i_prod_in = prod;
        i_key_in  = key;
        i_start   = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        n_accepted++;
        check({tag, ".busy"},     32'(o_busy),    32'(key != 4'd0));
        check({tag, ".flagclr"},  32'(o_div_err), 32'(err));
        lat = 0;
        while (o_done !== 1'b1 && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
            if (noise) begin
                i_start   = (lat == 2 || lat == 3 || lat == 8);
                i_prod_in = 8'hFF;
                i_key_in  = 4'h1;
            end
        end
        i_start = 1'b0;
        check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        check_outputs(tag, num, rem, ovf, err);
        @(posedge clk);
        #1;
        check({tag, ".pulse"},  32'(o_done), 32'd0);
        check({tag, ".idle"},   32'(o_busy), 32'd0);
        check_outputs({tag, ".hold"}, num, rem, ovf, err);
    endtask

    initial begin
        rst       = 1'b1;
        i_start   = 1'b0;
        i_prod_in = '0;
        i_key_in  = '0;
        #12;
        check("rst.busy", 32'(o_busy), 32'd0);
        check("rst.done", 32'(o_done), 32'd0);
        check_outputs("rst", 4'h0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle.busy", 32'(o_busy), 32'd0);

        //      tag     prod    key   lat num   rem   ovf   err   noise
        run_op("t1a",   8'h10,  4'h8, 9,  4'h8, 4'h0, 1'b0, 1'b0, 1'b0);
        run_op("t2a",   8'h30,  4'h8, 9,  4'h9, 4'h0, 1'b0, 1'b0, 1'b0);
        run_op("t2b",   8'h1E,  4'hA, 9,  4'hC, 4'h0, 1'b0, 1'b0, 1'b0);
        run_op("t3a",   8'hC4,  4'hE, 9,  4'hB, 4'h0, 1'b0, 1'b0, 1'b0);
        run_op("t3b",   8'h11,  4'h8, 9,  4'h8, 4'h1, 1'b0, 1'b0, 1'b0);
        run_op("t4z",   8'h5A,  4'h0, 1,  4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        run_op("t4c",   8'hEF,  4'hF, 9,  4'hF, 4'hE, 1'b0, 1'b0, 1'b0);
        run_op("t5a",   8'hFF,  4'h1, 9,  4'hF, 4'h0, 1'b1, 1'b0, 1'b0);
        run_op("t5b",   8'hFF,  4'hF, 9,  4'h4, 4'h0, 1'b1, 1'b0, 1'b0);
        run_op("t6n",   8'h30,  4'h8, 9,  4'h9, 4'h0, 1'b0, 1'b0, 1'b1);

        // Outputs hold while idle
        repeat (5) @(negedge clk);
        check_outputs("hold", 4'h9, 4'h0, 1'b0, 1'b0);
        check("count.before", 32'(n_done), 32'(n_accepted));

        // Reset during the 4th DIV cycle aborts the division
        @(negedge clk);
        i_prod_in = 8'hC4;
        i_key_in  = 4'hE;
        i_start   = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("abort.busy_pre", 32'(o_busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort.busy", 32'(o_busy), 32'd0);
        check("abort.done", 32'(o_done), 32'd0);
        check_outputs("abort", 4'h0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("abort.busy_after", 32'(o_busy), 32'd0);
        check("abort.nodone", 32'(n_done), 32'(n_accepted));

        // Normal operation resumes after the abort
        run_op("post",  8'h10,  4'h8, 9,  4'h8, 4'h0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("count.final", 32'(n_done), 32'(n_accepted));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
`default_nettype wire
